vc_to_d_arbiter: RTL and testbench
==================================

// Module: vc_to_d_arbiter
// PURPOSE
//  Stage between the virtual-channel FIFOs (VC0, VC1) and the destination FIFOs (D0, D1).
//  Pops one word per cycle from VC0/VC1 (VC0 priority, with an anti-starvation limit).
//  Routes each word by its destination bit to D0 or D1.
//  Honours the D0/D1 almost-full pauses and keeps per-destination word counters for the checker.
// PARAMETERS
//  BITNUMBER  8  data word width
//  DEST_BIT   4  index of destination bit in word (0 -> D0, 1 -> D1)
//  MAX_CONSEC 4  max consecutive VC0 grants while VC1 is eligible (1..15)
//  CNT_W      5  width of per-destination word counters
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          asynchronous, active-low reset
//  vc0_empty  in   1          VC0 FIFO empty
//  vc1_empty  in   1          VC1 FIFO empty
//  vc0_data   in   BITNUMBER  VC0 head word (first-word-fall-through, valid when !vc0_empty)
//  vc1_data   in   BITNUMBER  VC1 head word (first-word-fall-through, valid when !vc1_empty)
//  D0_pause   in   1          D0 FIFO almost-full (umbral reached)
//  D1_pause   in   1          D1 FIFO almost-full (umbral reached)
//  vc0_pop    out  1          pop VC0 this cycle (combinational)
//  vc1_pop    out  1          pop VC1 this cycle (combinational)
//  push_D0    out  1          push data_out into D0 (registered)
//  push_D1    out  1          push data_out into D1 (registered)
//  data_out   out  BITNUMBER  word to destination FIFOs (registered)
//  idle       out  1          registered; 1 when both VCs are empty and no push is pending
//  cnt_req    in   1          counter read request
//  cnt_idx    in   1          counter select (0 -> D0 count, 1 -> D1 count)
//  cnt_valid  out  1          cnt_data valid, one cycle after cnt_req
//  cnt_data   out  CNT_W      selected counter value
// BEHAVIOUR
//  Reset (reset == 0, asynchronous): push_D0, push_D1, data_out, cnt_valid, cnt_data = 0.
//   Also on reset: counters = 0, consec = 0, state = IDLE, idle = 1.
//   vc0_pop and vc1_pop are forced to 0 while reset is low.
//  Eligibility: VCn is eligible when !vcn_empty and the D pause selected by vcn_data[DEST_BIT] is 0.
//  Grant (combinational):
//   - Only VC0 eligible -> pop VC0. Only VC1 eligible -> pop VC1.
//   - Both eligible -> VC0, unless consec == MAX_CONSEC; then VC1.
//   - At most one pop per cycle. No pop when neither VC is eligible.
//  consec register, updated each cycle:
//   - +1 on a VC0 grant while VC1 is eligible (saturates at MAX_CONSEC).
//   - 0 on any VC1 grant, or when VC1 is not eligible.
//   - Unchanged when nothing is granted.
//  Latency: 1 cycle. The word popped in cycle N appears on data_out with push_Dx = 1 in cycle N+1.
//   x = word[DEST_BIT]. Exactly one of push_D0/push_D1 is high per pushed word.
//   With no grant, both pushes are 0 and data_out holds its last value.
//  Pause is sampled in the pop cycle only. A word already registered is pushed in N+1 even if pause rises in N+1.
//   The D-FIFO umbral guarantees one slot of margin.
//  FSM: IDLE <-> ACTIVE.
//   - IDLE -> ACTIVE on any grant.
//   - ACTIVE -> IDLE in a cycle with no grant; the pending push still completes in that cycle.
//   - idle = (state == IDLE) && vc0_empty && vc1_empty && !push_D0 && !push_D1 (registered).
//  Counters: cnt_D0 / cnt_D1 increment on each push_D0 / push_D1.
//   Counters are CNT_W bits wide and wrap from 2^CNT_W-1 to 0.
//  Counter read: cnt_req in cycle N -> cnt_valid = 1 and cnt_data = selected count in N+1.
//   The value read is the count before any increment in cycle N.
//   cnt_valid = 0 and cnt_data holds its last value when cnt_req is 0.
//  Simultaneous events: a counter increment and a counter read in the same cycle are both performed.
//   The read returns the pre-increment value.
//  Reset mid-operation: the in-flight word is dropped and pushes go low immediately.
//   Counters and consec clear. Nothing is popped until reset is released.
// TESTING
//  1. Reset low 2 cycles, then release with both VCs empty -> all outputs 0, idle = 1, no pops.
//  2. VC0 holds 0x15, 0x05; VC1 empty; no pause.
//     -> pops in cycles 0 and 1; push_D1 with 0x15 in cycle 1; push_D0 with 0x05 in cycle 2.
//  3. Both VCs continuously non-empty, all words to D0, MAX_CONSEC = 4.
//     -> grant sequence VC0 x4, VC1 x1, repeating; consec returns to 0 after each VC1 grant.
//  4. D1_pause = 1; VC0 head 0x10 (dest D1); VC1 head 0x02 (dest D0).
//     -> VC0 not popped, VC1 popped, push_D0 with 0x02.
//     -> Drop D1_pause: VC0 popped the next cycle.
//  5. Push 33 words to D0, then cnt_req = 1 with cnt_idx = 0 -> cnt_valid = 1, cnt_data = 1 (wrapped at 32).
//  6. Assert reset while both VCs are streaming -> pushes 0 the same cycle, counters 0.
//     -> After release, traffic resumes with the current VC heads.

Source files
------------

// File: rtl/vc_to_d_arbiter.sv
// vc_to_d_arbiter: pops VC0/VC1 (VC0 priority, bounded by an anti-starvation limit) and routes each word to D0 or D1.
module vc_to_d_arbiter #(
  parameter int BITNUMBER  = 8,
  parameter int DEST_BIT   = 4,
  parameter int MAX_CONSEC = 4,
  parameter int CNT_W      = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vc0_empty,
  input  logic                 vc1_empty,
  input  logic [BITNUMBER-1:0] vc0_data,
  input  logic [BITNUMBER-1:0] vc1_data,
  input  logic                 D0_pause,
  input  logic                 D1_pause,
  output logic                 vc0_pop,
  output logic                 vc1_pop,
  output logic                 push_D0,
  output logic                 push_D1,
  output logic [BITNUMBER-1:0] data_out,
  output logic                 idle,
  input  logic                 cnt_req,
  input  logic                 cnt_idx,
  output logic                 cnt_valid,
  output logic [CNT_W-1:0]     cnt_data
);
  localparam logic [3:0] MAXC = 4'(MAX_CONSEC);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_next;
  logic [3:0] consec, consec_next;
  logic [CNT_W-1:0] cnt_d0, cnt_d1;
  logic elig0, elig1, grant;
  logic [BITNUMBER-1:0] word;
  always_comb begin
    elig0 = !vc0_empty && !(vc0_data[DEST_BIT] ? D1_pause : D0_pause);
    elig1 = !vc1_empty && !(vc1_data[DEST_BIT] ? D1_pause : D0_pause);
    vc0_pop = reset && elig0 && !(elig1 && consec == MAXC);
    vc1_pop = reset && elig1 && !vc0_pop;
    grant = vc0_pop || vc1_pop;
    word = vc0_pop ? vc0_data : vc1_data;
    // A VC0 win only counts against VC1 when VC1 was actually waiting
    consec_next = !grant ? consec : (vc0_pop && elig1) ? (consec == MAXC ? consec : consec + 4'd1) : 4'd0;
    state_next = grant ? ACTIVE : IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      consec <= '0;
      push_D0 <= 1'b0;
      push_D1 <= 1'b0;
      data_out <= '0;
      idle <= 1'b1;
      cnt_d0 <= '0;
      cnt_d1 <= '0;
      cnt_valid <= 1'b0;
      cnt_data <= '0;
    end else begin
      consec <= consec_next;
      push_D0 <= grant && !word[DEST_BIT];
      push_D1 <= grant && word[DEST_BIT];
      if (grant) data_out <= word;
      idle <= (state == IDLE) && vc0_empty && vc1_empty && !push_D0 && !push_D1;
      cnt_d0 <= cnt_d0 + CNT_W'(push_D0);
      cnt_d1 <= cnt_d1 + CNT_W'(push_D1);
      cnt_valid <= cnt_req;
      if (cnt_req) cnt_data <= cnt_idx ? cnt_d1 : cnt_d0;
    end
endmodule

// File: tb/tb_vc_to_d_arbiter.sv
// tb_vc_to_d_arbiter: randomized and directed checks of vc_to_d_arbiter against a queue-based reference model.
module tb_vc_to_d_arbiter;
  localparam int BW = 8, DB = 4, MC = 4, CW = 5;
  logic clk = 0, reset = 0, vc0_empty = 1, vc1_empty = 1, D0_pause = 0, D1_pause = 0;
  logic cnt_req = 0, cnt_idx = 0;
  logic [BW-1:0] vc0_data = '0, vc1_data = '0, data_out;
  logic vc0_pop, vc1_pop, push_D0, push_D1, idle, cnt_valid;
  logic [CW-1:0] cnt_data;
  int n_checks = 0, n_fail = 0;
  logic [BW-1:0] q0[$], q1[$];
  int m_consec = 0, m_cnt0 = 0, m_cnt1 = 0;
  logic exp_pop0 = 0, exp_pop1 = 0, exp_push0 = 0, exp_push1 = 0, exp_valid = 0, exp_idle = 1;
  logic [BW-1:0] exp_data = '0;
  logic [CW-1:0] exp_cdata = '0;
  logic obs_pop0, obs_pop1;

  vc_to_d_arbiter #(.BITNUMBER(BW), .DEST_BIT(DB), .MAX_CONSEC(MC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .vc0_data(vc0_data), .vc1_data(vc1_data), .D0_pause(D0_pause), .D1_pause(D1_pause),
    .vc0_pop(vc0_pop), .vc1_pop(vc1_pop), .push_D0(push_D0), .push_D1(push_D1),
    .data_out(data_out), .idle(idle), .cnt_req(cnt_req), .cnt_idx(cnt_idx),
    .cnt_valid(cnt_valid), .cnt_data(cnt_data));

  always #5 clk = ~clk;

  // One clock: present FIFO heads, sample pops mid-cycle, advance the model, settle after the edge.
  task automatic cycle();
    logic e0, e1;
    logic [BW-1:0] w;
    vc0_empty = q0.size() == 0;
    vc0_data = vc0_empty ? '0 : q0[0];
    vc1_empty = q1.size() == 0;
    vc1_data = vc1_empty ? '0 : q1[0];
    @(negedge clk);
    obs_pop0 = vc0_pop;
    obs_pop1 = vc1_pop;
    if (!reset) begin
      exp_pop0 = 0; exp_pop1 = 0; m_consec = 0; m_cnt0 = 0; m_cnt1 = 0;
      exp_push0 = 0; exp_push1 = 0; exp_data = '0; exp_valid = 0; exp_cdata = '0; exp_idle = 1;
    end else begin
      e0 = !vc0_empty && !(vc0_data[DB] ? D1_pause : D0_pause);
      e1 = !vc1_empty && !(vc1_data[DB] ? D1_pause : D0_pause);
      exp_pop0 = e0 && !(e1 && m_consec == MC);
      exp_pop1 = e1 && !exp_pop0;
      exp_valid = cnt_req;
      if (cnt_req) exp_cdata = CW'(cnt_idx ? m_cnt1 : m_cnt0);
      exp_idle = vc0_empty && vc1_empty && !exp_push0 && !exp_push1;
      m_cnt0 = (m_cnt0 + (exp_push0 ? 1 : 0)) % (1 << CW);
      m_cnt1 = (m_cnt1 + (exp_push1 ? 1 : 0)) % (1 << CW);
      if (exp_pop0 || exp_pop1) begin
        w = exp_pop0 ? q0.pop_front() : q1.pop_front();
        exp_push0 = !w[DB]; exp_push1 = w[DB]; exp_data = w;
        m_consec = (exp_pop0 && e1) ? (m_consec < MC ? m_consec + 1 : MC) : 0;
      end else begin
        exp_push0 = 0; exp_push1 = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    while ((q0.size() > 0 || q1.size() > 0) && guard < 200) begin
      cycle();
      guard++;
    end
    cycle();
    n_checks++;
    if (guard >= 200) begin
      n_fail++;
      $display("FAIL drain_timeout: left q0=%0d q1=%0d, required 0", q0.size(), q1.size());
    end
  endtask

  task automatic test_reset();
    reset = 0;
    q0 = {8'h03};
    cycle();
    cycle();
    n_checks++; if (obs_pop0 !== 1'b0) begin n_fail++; $display("FAIL reset_pop0: got %b expected 0", obs_pop0); end
    n_checks++; if ({push_D0, push_D1} !== 2'b00) begin n_fail++; $display("FAIL reset_push: got %b expected 00", {push_D0, push_D1}); end
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data_out); end
    n_checks++; if ({cnt_valid, cnt_data} !== '0) begin n_fail++; $display("FAIL reset_cnt: got %b/%h expected 0/0", cnt_valid, cnt_data); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b expected 1", idle); end
    q0.delete();
    reset = 1;
    cycle();
    n_checks++; if ({obs_pop0, obs_pop1} !== 2'b00) begin n_fail++; $display("FAIL release_pop: got %b expected 00", {obs_pop0, obs_pop1}); end
    n_checks++; if (idle !== 1'b1 || push_D0 !== 1'b0 || push_D1 !== 1'b0) begin n_fail++; $display("FAIL release_idle: got idle=%b push=%b%b expected 1/00", idle, push_D0, push_D1); end
  endtask

  task automatic test_route();
    q0 = {8'h15, 8'h05};
    cycle();
    n_checks++; if (obs_pop0 !== 1'b1 || obs_pop1 !== 1'b0) begin n_fail++; $display("FAIL route_pop_a: got %b%b expected 10", obs_pop0, obs_pop1); end
    n_checks++; if (push_D1 !== 1'b1 || push_D0 !== 1'b0 || data_out !== 8'h15) begin n_fail++; $display("FAIL route_d1: got %b%b %h expected 01 15", push_D0, push_D1, data_out); end
    cycle();
    n_checks++; if (obs_pop0 !== 1'b1) begin n_fail++; $display("FAIL route_pop_b: got %b expected 1", obs_pop0); end
    n_checks++; if (push_D0 !== 1'b1 || push_D1 !== 1'b0 || data_out !== 8'h05) begin n_fail++; $display("FAIL route_d0: got %b%b %h expected 10 05", push_D0, push_D1, data_out); end
    cycle();
    n_checks++; if ({obs_pop0, push_D0, push_D1} !== 3'b000 || data_out !== 8'h05) begin n_fail++; $display("FAIL route_hold: got %b%b%b %h expected 000 05", obs_pop0, push_D0, push_D1, data_out); end
  endtask

  task automatic test_starvation();
    for (int i = 0; i < 25; i++) begin
      q0.push_back(8'($urandom) & 8'hEF);
      q1.push_back(8'($urandom) & 8'hEF);
    end
    for (int i = 0; i < 20; i++) begin
      cycle();
      n_checks++;
      if (obs_pop0 !== (i % 5 != 4) || obs_pop1 !== (i % 5 == 4)) begin
        n_fail++; $display("FAIL starve_grant[%0d]: got %b%b expected %b%b", i, obs_pop0, obs_pop1, i % 5 != 4, i % 5 == 4);
      end
      n_checks++;
      if (push_D0 !== exp_push0 || data_out !== exp_data) begin
        n_fail++; $display("FAIL starve_push[%0d]: got %b %h expected %b %h", i, push_D0, data_out, exp_push0, exp_data);
      end
    end
    drain();
  endtask

  task automatic test_pause();
    q0 = {8'h10};
    q1 = {8'h02};
    D1_pause = 1;
    cycle();
    n_checks++; if (obs_pop0 !== 1'b0 || obs_pop1 !== 1'b1) begin n_fail++; $display("FAIL pause_pop: got %b%b expected 01", obs_pop0, obs_pop1); end
    n_checks++; if (push_D0 !== 1'b1 || data_out !== 8'h02) begin n_fail++; $display("FAIL pause_push: got %b %h expected 1 02", push_D0, data_out); end
    cycle();
    n_checks++; if (obs_pop0 !== 1'b0) begin n_fail++; $display("FAIL pause_hold: got %b expected 0", obs_pop0); end
    D1_pause = 0;
    cycle();
    n_checks++; if (obs_pop0 !== 1'b1 || push_D1 !== 1'b1 || data_out !== 8'h10) begin n_fail++; $display("FAIL unpause: got %b %b %h expected 1 1 10", obs_pop0, push_D1, data_out); end
    cycle();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) begin
      q0.push_back(8'($urandom));
      q1.push_back(8'($urandom));
    end
    repeat (3) cycle();
    reset = 0;
    #1;
    n_checks++; if ({push_D0, push_D1} !== 2'b00) begin n_fail++; $display("FAIL midreset_push: got %b%b expected 00", push_D0, push_D1); end
    cycle();
    n_checks++; if ({obs_pop0, obs_pop1} !== 2'b00) begin n_fail++; $display("FAIL midreset_pop: got %b%b expected 00", obs_pop0, obs_pop1); end
    reset = 1;
    cnt_req = 1;
    cnt_idx = 0;
    cycle();
    n_checks++; if ((obs_pop0 | obs_pop1) !== 1'b1 || obs_pop0 !== exp_pop0) begin n_fail++; $display("FAIL resume_pop: got %b%b expected %b%b", obs_pop0, obs_pop1, exp_pop0, exp_pop1); end
    n_checks++; if (cnt_valid !== 1'b1 || cnt_data !== 5'd0) begin n_fail++; $display("FAIL cleared_cnt0: got %b/%0d expected 1/0", cnt_valid, cnt_data); end
    cnt_idx = 1;
    cycle();
    n_checks++; if (cnt_data !== 5'd0 || data_out !== exp_data) begin n_fail++; $display("FAIL cleared_cnt1: got %0d %h expected 0 %h", cnt_data, data_out, exp_data); end
    cnt_req = 0;
    drain();
  endtask

  task automatic test_wrap();
    int guard = 0;
    reset = 0;
    cycle();
    reset = 1;
    for (int i = 0; i < 33; i++) q0.push_back(8'($urandom) & 8'hEF);
    while (q0.size() > 0 && guard < 100) begin
      cycle();
      guard++;
      n_checks++;
      if (push_D0 !== exp_push0 || data_out !== exp_data) begin n_fail++; $display("FAIL wrap_push: got %b %h expected %b %h", push_D0, data_out, exp_push0, exp_data); end
    end
    cycle();
    cnt_req = 1;
    cnt_idx = 0;
    cycle();
    cnt_req = 0;
    n_checks++; if (cnt_valid !== 1'b1 || cnt_data !== 5'd1) begin n_fail++; $display("FAIL wrap_cnt: got %b/%0d expected 1/1", cnt_valid, cnt_data); end
    cycle();
    n_checks++; if (cnt_valid !== 1'b0 || cnt_data !== 5'd1) begin n_fail++; $display("FAIL cnt_hold: got %b/%0d expected 0/1", cnt_valid, cnt_data); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (q0.size() < 8 && $urandom_range(1, 0) == 1) q0.push_back(8'($urandom));
      if (q1.size() < 8 && $urandom_range(3, 0) != 0) q1.push_back(8'($urandom));
      D0_pause = $urandom_range(3, 0) == 0;
      D1_pause = $urandom_range(3, 0) == 0;
      cnt_req = $urandom_range(2, 0) == 0;
      cnt_idx = 1'($urandom);
      cycle();
      n_checks++; if (obs_pop0 !== exp_pop0 || obs_pop1 !== exp_pop1) begin n_fail++; $display("FAIL rnd_pop[%0d]: got %b%b expected %b%b", i, obs_pop0, obs_pop1, exp_pop0, exp_pop1); end
      n_checks++; if (push_D0 !== exp_push0 || push_D1 !== exp_push1) begin n_fail++; $display("FAIL rnd_push[%0d]: got %b%b expected %b%b", i, push_D0, push_D1, exp_push0, exp_push1); end
      n_checks++; if (data_out !== exp_data) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h expected %h", i, data_out, exp_data); end
      n_checks++; if (cnt_valid !== exp_valid || cnt_data !== exp_cdata) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %b/%0d expected %b/%0d", i, cnt_valid, cnt_data, exp_valid, exp_cdata); end
      n_checks++; if (idle !== exp_idle) begin n_fail++; $display("FAIL rnd_idle[%0d]: got %b expected %b", i, idle, exp_idle); end
    end
    D0_pause = 0;
    D1_pause = 0;
    cnt_req = 0;
    drain();
  endtask

  initial begin
    test_reset();
    test_route();
    test_starvation();
    test_pause();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
